// File: rtl/pkt_mux_nto1_if.sv
// -----------------------------------------------------------------------------
// pkt_mux_nto1_if
//   Bundles the request, per-port read-beat and forwarded-beat signals of the
//   packet-aware N-to-1 read-data mux.
//
//   slave  modport : the mux itself (consumes i_*, drives o_*)
//   master modport : the environment (drives i_*, observes o_*)
//
//   i_en        block enable, 0 aborts and flushes
//   i_sel_vld   select request strobe
//   i_sel       requested input port
//   i_rd_*      per-port sop / eop / vld / data (unpacked, one entry per port)
//   o_rd_*      forwarded sop / eop / vld / data
//   o_busy      mux is armed or transferring
//   o_cur_sel   latched port
//   o_pkt_cnt   completed packets, wrapping
//   o_err       sticky protocol error
// -----------------------------------------------------------------------------
interface pkt_mux_nto1_if #(
  parameter int PORT_NUM   = 16,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
);
  localparam int SEL_W = $clog2(PORT_NUM);

  logic                  i_en;
  logic                  i_sel_vld;
  logic [SEL_W-1:0]      i_sel;
  logic                  i_rd_sop  [PORT_NUM];
  logic                  i_rd_eop  [PORT_NUM];
  logic                  i_rd_vld  [PORT_NUM];
  logic [DATA_WIDTH-1:0] i_rd_data [PORT_NUM];

  logic                  o_rd_sop;
  logic                  o_rd_eop;
  logic                  o_rd_vld;
  logic [DATA_WIDTH-1:0] o_rd_data;
  logic                  o_busy;
  logic [SEL_W-1:0]      o_cur_sel;
  logic [CNT_WIDTH-1:0]  o_pkt_cnt;
  logic                  o_err;

  modport slave (
    input  i_en, i_sel_vld, i_sel, i_rd_sop, i_rd_eop, i_rd_vld, i_rd_data,
    output o_rd_sop, o_rd_eop, o_rd_vld, o_rd_data, o_busy, o_cur_sel,
           o_pkt_cnt, o_err
  );

  modport master (
    output i_en, i_sel_vld, i_sel, i_rd_sop, i_rd_eop, i_rd_vld, i_rd_data,
    input  o_rd_sop, o_rd_eop, o_rd_vld, o_rd_data, o_busy, o_cur_sel,
           o_pkt_cnt, o_err
  );
endinterface

// File: rtl/pkt_mux_nto1.sv
// -----------------------------------------------------------------------------
// pkt_mux_nto1
//   Registered, packet-aware N-to-1 read-data mux. A select request latches one
//   input port; the port stays locked from its SOP beat through its EOP beat so
//   a packet is never split. Forwarded beats appear one cycle after the input
//   beat, completed packets are counted and protocol errors are flagged.
//
//   i_clk    clock
//   i_rst_n  synchronous active-low reset
//   bus      pkt_mux_nto1_if.slave (request, per-port beats, forwarded beats,
//            status: o_busy, o_cur_sel, o_pkt_cnt, o_err)
// -----------------------------------------------------------------------------
module pkt_mux_nto1 #(
  parameter int PORT_NUM   = 16,
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 16
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  pkt_mux_nto1_if.slave bus
);
  localparam int SEL_W = $clog2(PORT_NUM);
  // One extra bit so that PORT_NUM itself is representable for the range check.
  localparam logic [SEL_W:0]       PORT_NUM_W = (SEL_W + 1)'(PORT_NUM);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = {{(CNT_WIDTH - 1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    XFER  = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [SEL_W-1:0]      cur_sel_r;
  logic [SEL_W-1:0]      cur_sel_nxt_s;
  logic                  fwd_s;
  logic                  done_s;
  logic                  err_set_s;

  logic                  beat_vld_s;
  logic                  beat_sop_s;
  logic                  beat_eop_s;
  logic [DATA_WIDTH-1:0] beat_data_s;

  logic                  rd_sop_r;
  logic                  rd_eop_r;
  logic                  rd_vld_r;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  busy_r;
  logic [CNT_WIDTH-1:0]  pkt_cnt_r;
  logic                  err_r;

  // Only the latched port is ever looked at; all other ports are invisible.
  assign beat_vld_s  = bus.i_rd_vld[cur_sel_r];
  assign beat_sop_s  = bus.i_rd_sop[cur_sel_r];
  assign beat_eop_s  = bus.i_rd_eop[cur_sel_r];
  assign beat_data_s = bus.i_rd_data[cur_sel_r];

  // Next-state, port latching, forward/complete/error decisions.
  always_comb begin
    state_nxt_s   = state_r;
    cur_sel_nxt_s = cur_sel_r;
    fwd_s         = 1'b0;
    done_s        = 1'b0;
    err_set_s     = 1'b0;
    if (!bus.i_en) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          // A SOP arriving together with the request is not captured: the
          // beat mux still points at the previously latched port this cycle.
          if (bus.i_sel_vld) begin
            if ({1'b0, bus.i_sel} < PORT_NUM_W) begin
              state_nxt_s   = ARMED;
              cur_sel_nxt_s = bus.i_sel;
            end else begin
              err_set_s = 1'b1;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end
        ARMED: begin
          if (beat_vld_s) begin
            if (beat_sop_s) begin
              fwd_s = 1'b1;
              if (beat_eop_s) begin
                done_s      = 1'b1;
                state_nxt_s = IDLE;
              end else begin
                state_nxt_s = XFER;
              end
            end else begin
              // Stray body beat before any SOP: dropped and flagged.
              err_set_s = 1'b1;
            end
          end else begin
            state_nxt_s = ARMED;
          end
        end
        XFER: begin
          if (beat_vld_s) begin
            fwd_s     = 1'b1;
            // A restart mid-packet is forwarded but flagged.
            err_set_s = beat_sop_s;
            if (beat_eop_s) begin
              done_s      = 1'b1;
              state_nxt_s = IDLE;
            end else begin
              state_nxt_s = XFER;
            end
          end else begin
            state_nxt_s = XFER;
          end
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State, latched port, registered outputs, packet counter and sticky error.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r   <= IDLE;
      cur_sel_r <= {SEL_W{1'b0}};
      rd_sop_r  <= 1'b0;
      rd_eop_r  <= 1'b0;
      rd_vld_r  <= 1'b0;
      rd_data_r <= {DATA_WIDTH{1'b0}};
      busy_r    <= 1'b0;
      pkt_cnt_r <= {CNT_WIDTH{1'b0}};
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cur_sel_r <= cur_sel_nxt_s;
      rd_sop_r  <= fwd_s & beat_sop_s;
      rd_eop_r  <= fwd_s & beat_eop_s;
      rd_vld_r  <= fwd_s;
      rd_data_r <= fwd_s ? beat_data_s : {DATA_WIDTH{1'b0}};
      busy_r    <= (state_nxt_s != IDLE);
      if (done_s) begin
        pkt_cnt_r <= pkt_cnt_r + CNT_ONE;
      end else begin
        pkt_cnt_r <= pkt_cnt_r;
      end
      if (err_set_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign bus.o_rd_sop  = rd_sop_r;
  assign bus.o_rd_eop  = rd_eop_r;
  assign bus.o_rd_vld  = rd_vld_r;
  assign bus.o_rd_data = rd_data_r;
  assign bus.o_busy    = busy_r;
  assign bus.o_cur_sel = cur_sel_r;
  assign bus.o_pkt_cnt = pkt_cnt_r;
  assign bus.o_err     = err_r;

endmodule

// File: tb/tb_pkt_mux_nto1.sv
// -----------------------------------------------------------------------------
// tb_pkt_mux_nto1
//   Self-checking bench for pkt_mux_nto1 with PORT_NUM=12 (non power of two)
//   and CNT_WIDTH=2 (fast counter wrap). Every cycle the DUT is compared with a
//   transaction-level reference model; a directed vector table and hand-written
//   sequences add fixed expectations on top.
// -----------------------------------------------------------------------------
module tb_pkt_mux_nto1;
  localparam int PN = 12;
  localparam int DW = 64;
  localparam int CW = 2;
  localparam int SW = $clog2(PN);

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  pkt_mux_nto1_if #(.PORT_NUM(PN), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) bus ();

  pkt_mux_nto1 #(.PORT_NUM(PN), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int            m_lock;    // locked port, -1 when idle
  bit            m_inpkt;   // SOP already seen for the locked port
  logic [CW-1:0] m_cnt;
  logic          m_err;
  logic [SW-1:0] m_sel;
  logic          e_vld, e_sop, e_eop, e_busy;
  logic [DW-1:0] e_data;

  function automatic void model_step();
    int p;
    e_vld = 1'b0; e_sop = 1'b0; e_eop = 1'b0; e_data = 64'd0;
    if (!rst_n) begin
      m_lock = -1; m_inpkt = 1'b0; m_cnt = 2'd0; m_err = 1'b0; m_sel = 4'd0;
    end else if (!bus.i_en) begin
      m_lock = -1; m_inpkt = 1'b0;
    end else if (m_lock < 0) begin
      if (bus.i_sel_vld) begin
        if (int'(bus.i_sel) < PN) begin
          m_lock = int'(bus.i_sel); m_sel = bus.i_sel; m_inpkt = 1'b0;
        end else begin
          m_err = 1'b1;
        end
      end
    end else begin
      p = m_lock;
      if (bus.i_rd_vld[p]) begin
        if (!m_inpkt && !bus.i_rd_sop[p]) begin
          m_err = 1'b1;
        end else begin
          e_vld = 1'b1; e_sop = bus.i_rd_sop[p]; e_eop = bus.i_rd_eop[p];
          e_data = bus.i_rd_data[p];
          if (m_inpkt && bus.i_rd_sop[p]) m_err = 1'b1;
          if (bus.i_rd_eop[p]) begin
            m_cnt = m_cnt + 2'd1; m_lock = -1; m_inpkt = 1'b0;
          end else begin
            m_inpkt = 1'b1;
          end
        end
      end
    end
    e_busy = (m_lock >= 0);
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clr_ports();
    for (int i = 0; i < PN; i++) begin
      bus.i_rd_vld[i] = 1'b0; bus.i_rd_sop[i] = 1'b0;
      bus.i_rd_eop[i] = 1'b0; bus.i_rd_data[i] = 64'd0;
    end
  endtask

  task automatic drv(input int p, input logic v, input logic s, input logic e, input logic [63:0] d);
    bus.i_rd_vld[p] = v; bus.i_rd_sop[p] = s; bus.i_rd_eop[p] = e; bus.i_rd_data[p] = d;
  endtask

  task automatic set_ctl(input logic r, input logic en, input logic sv, input logic [SW-1:0] sel);
    rst_n = r; bus.i_en = en; bus.i_sel_vld = sv; bus.i_sel = sel;
  endtask

  // Predict, clock, then compare every output against the model.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("m_vld",  {63'd0, bus.o_rd_vld}, {63'd0, e_vld});
    chk("m_sop",  {63'd0, bus.o_rd_sop}, {63'd0, e_sop});
    chk("m_eop",  {63'd0, bus.o_rd_eop}, {63'd0, e_eop});
    chk("m_data", bus.o_rd_data, e_data);
    chk("m_busy", {63'd0, bus.o_busy}, {63'd0, e_busy});
    chk("m_sel",  {60'd0, bus.o_cur_sel}, {60'd0, m_sel});
    chk("m_cnt",  {62'd0, bus.o_pkt_cnt}, {62'd0, m_cnt});
    chk("m_err",  {63'd0, bus.o_err}, {63'd0, m_err});
  endtask

  task automatic do_reset();
    set_ctl(1'b0, 1'b1, 1'b0, 4'd0);
    clr_ports();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct packed {
    logic          rst_n, en, sv;
    logic [SW-1:0] sel;
    int            port;
    logic          vld, sop, eop;
    logic [DW-1:0] data;
    logic          x_vld, x_sop, x_eop;
    logic [DW-1:0] x_data;
    logic          x_busy;
    logic [SW-1:0] x_cur;
    logic [CW-1:0] x_cnt;
    logic          x_err;
  } vec_t;

  vec_t          tbl [11];
  logic [CW-1:0] wrap_exp [5];

  initial begin
    errors = 0; checks = 0;
    m_lock = -1; m_inpkt = 1'b0; m_cnt = 2'd0; m_err = 1'b0; m_sel = 4'd0;
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    //          rst  en   sv   sel   port vld  sop  eop  data         -> vld  sop  eop  data        busy cur   cnt   err
    tbl[0]  = '{1'b0,1'b1,1'b1,4'd5, 5,   1'b1,1'b1,1'b0,64'hA0,      1'b0,1'b0,1'b0,64'h0,  1'b0,4'd0, 2'd0, 1'b0};
    tbl[1]  = '{1'b1,1'b1,1'b1,4'd5, 5,   1'b1,1'b1,1'b0,64'hA0,      1'b0,1'b0,1'b0,64'h0,  1'b1,4'd5, 2'd0, 1'b0};
    tbl[2]  = '{1'b1,1'b1,1'b0,4'd0, 5,   1'b1,1'b1,1'b0,64'hA0,      1'b1,1'b1,1'b0,64'hA0, 1'b1,4'd5, 2'd0, 1'b0};
    tbl[3]  = '{1'b1,1'b1,1'b0,4'd0, 5,   1'b1,1'b0,1'b0,64'hA1,      1'b1,1'b0,1'b0,64'hA1, 1'b1,4'd5, 2'd0, 1'b0};
    tbl[4]  = '{1'b1,1'b1,1'b0,4'd0, 5,   1'b0,1'b0,1'b0,64'hFF,      1'b0,1'b0,1'b0,64'h0,  1'b1,4'd5, 2'd0, 1'b0};
    tbl[5]  = '{1'b1,1'b1,1'b0,4'd0, 5,   1'b1,1'b0,1'b0,64'hA2,      1'b1,1'b0,1'b0,64'hA2, 1'b1,4'd5, 2'd0, 1'b0};
    tbl[6]  = '{1'b1,1'b1,1'b0,4'd0, 5,   1'b1,1'b0,1'b1,64'hA3,      1'b1,1'b0,1'b1,64'hA3, 1'b0,4'd5, 2'd1, 1'b0};
    tbl[7]  = '{1'b1,1'b1,1'b0,4'd0, 5,   1'b1,1'b1,1'b0,64'h55,      1'b0,1'b0,1'b0,64'h0,  1'b0,4'd5, 2'd1, 1'b0};
    tbl[8]  = '{1'b1,1'b1,1'b1,4'd12,5,   1'b0,1'b0,1'b0,64'h0,       1'b0,1'b0,1'b0,64'h0,  1'b0,4'd5, 2'd1, 1'b1};
    tbl[9]  = '{1'b1,1'b1,1'b1,4'd0, 0,   1'b0,1'b0,1'b0,64'h0,       1'b0,1'b0,1'b0,64'h0,  1'b1,4'd0, 2'd1, 1'b1};
    tbl[10] = '{1'b1,1'b1,1'b0,4'd0, 0,   1'b1,1'b1,1'b1,64'h10,      1'b1,1'b1,1'b1,64'h10, 1'b0,4'd0, 2'd2, 1'b1};

    set_ctl(1'b0, 1'b1, 1'b0, 4'd0);
    clr_ports();

    // Reset held 3 cycles with every port active: all outputs stay 0.
    set_ctl(1'b0, 1'b1, 1'b1, 4'd1);
    for (int i = 0; i < PN; i++) drv(i, 1'b1, 1'b1, 1'b1, 64'hFFFF_0000 + 64'(i));
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_vld",  {63'd0, bus.o_rd_vld}, 64'd0);
      chk("rst_data", bus.o_rd_data, 64'd0);
      chk("rst_busy", {63'd0, bus.o_busy}, 64'd0);
      chk("rst_cnt",  {62'd0, bus.o_pkt_cnt}, 64'd0);
      chk("rst_err",  {63'd0, bus.o_err}, 64'd0);
      chk("rst_sel",  {60'd0, bus.o_cur_sel}, 64'd0);
    end
    set_ctl(1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    chk("idle_busy", {63'd0, bus.o_busy}, 64'd0);
    chk("idle_vld",  {63'd0, bus.o_rd_vld}, 64'd0);

    // Vector table: basic 4-beat packet, idle activity, bad select, single beat.
    for (int t = 0; t < 11; t++) begin
      set_ctl(tbl[t].rst_n, tbl[t].en, tbl[t].sv, tbl[t].sel);
      clr_ports();
      drv(tbl[t].port, tbl[t].vld, tbl[t].sop, tbl[t].eop, tbl[t].data);
      tick();
      chk("tbl_vld",  {63'd0, bus.o_rd_vld},  {63'd0, tbl[t].x_vld});
      chk("tbl_sop",  {63'd0, bus.o_rd_sop},  {63'd0, tbl[t].x_sop});
      chk("tbl_eop",  {63'd0, bus.o_rd_eop},  {63'd0, tbl[t].x_eop});
      chk("tbl_data", bus.o_rd_data, tbl[t].x_data);
      chk("tbl_busy", {63'd0, bus.o_busy},    {63'd0, tbl[t].x_busy});
      chk("tbl_cur",  {60'd0, bus.o_cur_sel}, {60'd0, tbl[t].x_cur});
      chk("tbl_cnt",  {62'd0, bus.o_pkt_cnt}, {62'd0, tbl[t].x_cnt});
      chk("tbl_err",  {63'd0, bus.o_err},     {63'd0, tbl[t].x_err});
    end

    // Select locking: port 2 chatters and a reselect to 2 arrives mid-packet.
    do_reset();
    set_ctl(1'b1, 1'b1, 1'b1, 4'd5);
    clr_ports();
    drv(2, 1'b1, 1'b1, 1'b0, 64'h22);
    tick();
    for (int b = 0; b < 4; b++) begin
      set_ctl(1'b1, 1'b1, (b == 1), (b == 1) ? 4'd2 : 4'd5);
      clr_ports();
      drv(2, 1'b1, 1'b1, 1'b0, 64'h22);
      drv(5, 1'b1, (b == 0), (b == 3), 64'hA0 + 64'(b));
      tick();
      chk("lock_data", bus.o_rd_data, 64'hA0 + 64'(b));
      chk("lock_vld",  {63'd0, bus.o_rd_vld}, 64'd1);
      chk("lock_cur",  {60'd0, bus.o_cur_sel}, 64'd5);
    end
    chk("lock_cnt",  {62'd0, bus.o_pkt_cnt}, 64'd1);
    chk("lock_busy", {63'd0, bus.o_busy}, 64'd0);
    set_ctl(1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    chk("lock_after", {63'd0, bus.o_rd_vld}, 64'd0);

    // Five single-beat packets on port 0: counter wraps 1,2,3,0,1.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      set_ctl(1'b1, 1'b1, 1'b1, 4'd0);
      clr_ports();
      tick();
      set_ctl(1'b1, 1'b1, 1'b0, 4'd0);
      drv(0, 1'b1, 1'b1, 1'b1, 64'h100 + 64'(k));
      tick();
      chk("wrap_vld",  {63'd0, bus.o_rd_vld}, 64'd1);
      chk("wrap_data", bus.o_rd_data, 64'h100 + 64'(k));
      chk("wrap_cnt",  {62'd0, bus.o_pkt_cnt}, {62'd0, wrap_exp[k]});
    end

    // Out-of-range select with PORT_NUM=12.
    do_reset();
    set_ctl(1'b1, 1'b1, 1'b1, 4'd12);
    tick();
    chk("bad_sel_busy", {63'd0, bus.o_busy}, 64'd0);
    chk("bad_sel_err",  {63'd0, bus.o_err}, 64'd1);

    // Non-SOP beat while ARMED: dropped, error sticks until reset.
    do_reset();
    set_ctl(1'b1, 1'b1, 1'b1, 4'd3);
    tick();
    set_ctl(1'b1, 1'b1, 1'b0, 4'd0);
    drv(3, 1'b1, 1'b0, 1'b0, 64'h33);
    tick();
    chk("arm_drop_vld", {63'd0, bus.o_rd_vld}, 64'd0);
    chk("arm_err",      {63'd0, bus.o_err}, 64'd1);
    chk("arm_busy",     {63'd0, bus.o_busy}, 64'd1);
    drv(3, 1'b1, 1'b1, 1'b1, 64'h34);
    tick();
    chk("arm_fwd", bus.o_rd_data, 64'h34);
    clr_ports();
    for (int c = 0; c < 3; c++) tick();
    chk("arm_err_hold", {63'd0, bus.o_err}, 64'd1);
    do_reset();
    chk("arm_err_clr", {63'd0, bus.o_err}, 64'd0);

    // Abort with i_en=0 on beat 1, then a fresh packet after re-enable.
    set_ctl(1'b1, 1'b1, 1'b1, 4'd5);
    clr_ports();
    tick();
    set_ctl(1'b1, 1'b1, 1'b0, 4'd0);
    drv(5, 1'b1, 1'b1, 1'b0, 64'hA0);
    tick();
    chk("abort_b0", bus.o_rd_data, 64'hA0);
    set_ctl(1'b1, 1'b0, 1'b0, 4'd0);
    drv(5, 1'b1, 1'b0, 1'b0, 64'hA1);
    tick();
    chk("abort_vld",  {63'd0, bus.o_rd_vld}, 64'd0);
    chk("abort_busy", {63'd0, bus.o_busy}, 64'd0);
    chk("abort_cnt",  {62'd0, bus.o_pkt_cnt}, 64'd0);
    set_ctl(1'b1, 1'b1, 1'b0, 4'd0);
    drv(5, 1'b1, 1'b0, 1'b1, 64'hA3);
    tick();
    chk("abort_tail", {63'd0, bus.o_rd_vld}, 64'd0);
    chk("abort_cnt2", {62'd0, bus.o_pkt_cnt}, 64'd0);
    set_ctl(1'b1, 1'b1, 1'b1, 4'd5);
    clr_ports();
    tick();
    set_ctl(1'b1, 1'b1, 1'b0, 4'd0);
    drv(5, 1'b1, 1'b1, 1'b0, 64'hB0);
    tick();
    chk("reen_b0", bus.o_rd_data, 64'hB0);
    drv(5, 1'b1, 1'b0, 1'b1, 64'hB1);
    tick();
    chk("reen_b1",  bus.o_rd_data, 64'hB1);
    chk("reen_cnt", {62'd0, bus.o_pkt_cnt}, 64'd1);

    // Randomised traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      set_ctl(($urandom_range(0, 199) != 0), ($urandom_range(0, 49) != 0),
              ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 13)));
      for (int i = 0; i < PN; i++) begin
        drv(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 2) == 0), {$urandom, $urandom});
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pkt_mux_nto1.md
Name: pkt_mux_nto1

Overview:
- Parametrised, registered, packet-aware N-to-1 read-data mux for the multi-port cache read path.
- Replaces the combinational per-beat mux. A selected input port is locked from its SOP beat through its EOP beat, so a select change can never split a packet.
- Adds a one-cycle registered output, packet counting and protocol-error flagging. Sits between the per-input-port read buffers and one output port.

Parameters:
- PORT_NUM, 16, number of input ports (2..64).
- DATA_WIDTH, 64, width of each read-data beat.
- CNT_WIDTH, 16, width of the completed-packet counter.
- SEL_W (localparam), $clog2(PORT_NUM), select width.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_en  in  1  block enable; 0 aborts and flushes.
- i_sel_vld  in  1  select request strobe.
- i_sel  in  SEL_W  requested input port.
- i_rd_sop  in  1 x PORT_NUM (unpacked)  per-port start of packet.
- i_rd_eop  in  1 x PORT_NUM (unpacked)  per-port end of packet.
- i_rd_vld  in  1 x PORT_NUM (unpacked)  per-port beat valid.
- i_rd_data  in  DATA_WIDTH x PORT_NUM (unpacked)  per-port beat data.
- o_rd_sop  out  1  forwarded SOP.
- o_rd_eop  out  1  forwarded EOP.
- o_rd_vld  out  1  forwarded valid.
- o_rd_data  out  DATA_WIDTH  forwarded data.
- o_busy  out  1  1 whenever state is not IDLE.
- o_cur_sel  out  SEL_W  latched port.
- o_pkt_cnt  out  CNT_WIDTH  completed packets, wrapping.
- o_err  out  1  sticky protocol error.

Behaviour:
- Reset: all regs update only on rising i_clk. When i_rst_n=0 at an edge:
  - state goes to IDLE;
  - every output goes to 0 (o_rd_*, o_busy, o_cur_sel, o_pkt_cnt, o_err).
  - Reset mid-packet discards the packet with no counter update.
- Latency: every forwarded beat appears exactly 1 cycle after the input beat. o_rd_data is zero on non-valid cycles.
- FSM, IDLE -> ARMED:
  - Condition: i_sel_vld=1 and i_sel<PORT_NUM.
  - Latch i_sel into o_cur_sel.
  - If i_sel>=PORT_NUM: stay IDLE and set o_err.
- FSM, ARMED:
  - Discard latched-port beats until one arrives with vld=1 and sop=1.
  - Forward that SOP beat, then go to XFER.
  - If the SOP beat also has eop=1 (single-beat packet): go to IDLE and increment o_pkt_cnt.
  - Beats on the latched port with vld=1, sop=0 are dropped and set o_err.
- FSM, XFER:
  - Forward every beat with vld=1 from the latched port.
  - On a beat with vld=1 and eop=1: go to IDLE and increment o_pkt_cnt.
  - A beat with sop=1 mid-packet is forwarded, sets o_err, and stays in XFER (treated as a new packet start).
- i_sel_vld is ignored outside IDLE; no queuing.
- Non-selected ports are never forwarded in any state.
- i_en=0 at an edge:
  - state goes to IDLE;
  - next-cycle o_rd_* are 0;
  - o_pkt_cnt and o_err are held.
- o_pkt_cnt wraps from all-ones to 0 with no flag.
- o_err clears only on reset.
- Simultaneous events:
  - IDLE with i_sel_vld: the select is latched at that edge. A SOP on that port in the same cycle is NOT captured; capture starts the following cycle.
  - EOP in XFER with i_sel_vld in the same cycle: the EOP edge goes to IDLE and the request is dropped.

Test Plan:
- Reset/idle: hold i_rst_n=0 for 3 cycles, then drive vld/sop on all ports -> all outputs 0, o_busy=0.
- Basic packet: i_sel_vld with i_sel=5, then port5 sends a 4-beat packet (data 0xA0..0xA3, sop on beat0, eop on beat3) -> identical beats on o_rd_* each 1 cycle later; o_pkt_cnt=1; o_busy drops the cycle after EOP.
- Select locking: mid-packet on port5, pulse i_sel_vld with i_sel=2 while port2 is active -> port2 never forwarded; port5 packet intact; o_cur_sel stays 5.
- Single-beat and wrap: set CNT_WIDTH=2 and send 5 single-beat packets (sop=eop=1) on port 0 -> 5 beats forwarded; o_pkt_cnt sequence 1,2,3,0,1.
- Errors:
  - i_sel=PORT_NUM (with PORT_NUM non-power-of-2, e.g. 12) -> stays IDLE, o_err=1.
  - Separately, in ARMED, a non-SOP valid beat arrives -> beat dropped, o_err=1, held until reset.
- Abort: i_en=0 on the 2nd beat of a 4-beat packet -> o_rd_vld=0 the next cycle; state IDLE; o_pkt_cnt unchanged. After re-enable, a fresh select and packet pass normally.
